// File: rtl/feedback_period_monitor.sv
// Sysclk-domain monitor for the feedback counter marker: counts groups, measures marker period,
// flags stalls. Define FBMON_OVERRUN_EN to drop (and flag) captures made while a value is pending.
module feedback_period_monitor #(
    parameter int CNT_W   = 16,
    parameter int GRP_W   = 8,
    parameter int TIMEOUT = 1000
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             fb_in,
    input  logic             enable,
    input  logic             clr_flags,
    input  logic             period_ready,
    output logic [CNT_W-1:0] period_out,
    output logic             period_valid,
    output logic [GRP_W-1:0] group_count,
    output logic             timeout,
    output logic             overrun
);

    // state   | meaning
    // IDLE    | disabled, counter cleared
    // ARM     | enabled, waiting for first marker (no period reference yet)
    // MEASURE | reference marker seen, counting towards next capture
    // TMO     | no marker for TIMEOUT cycles, waiting for a new reference
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARM     = 2'd1,
        S_MEASURE = 2'd2,
        S_TMO     = 2'd3
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             fb_dly_q;
    logic [CNT_W-1:0] period_q;
    logic             valid_q;
    logic [GRP_W-1:0] grp_q;
    logic             timeout_q;

    logic             ev;
    logic             at_limit;
    logic [CNT_W-1:0] cnt_inc_d;

    assign ev        = fb_dly_q & ~fb_in;
    assign at_limit  = (32'(cnt_q) == 32'(TIMEOUT - 1));
    // Saturating increment doubles as the captured period min(cnt+1, max).
    assign cnt_inc_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

`ifdef FBMON_OVERRUN_EN
    logic overrun_q;
    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

    always_ff @(posedge sysclk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            fb_dly_q  <= 1'b1;
            period_q  <= '0;
            valid_q   <= 1'b0;
            grp_q     <= '0;
            timeout_q <= 1'b0;
`ifdef FBMON_OVERRUN_EN
            overrun_q <= 1'b0;
`endif
        end else begin
            fb_dly_q <= fb_in;
            if (clr_flags) begin
                timeout_q <= 1'b0;
`ifdef FBMON_OVERRUN_EN
                overrun_q <= 1'b0;
`endif
            end
            if (valid_q && period_ready) valid_q <= 1'b0;

            if (!enable) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
                valid_q <= 1'b0;
            end else begin
                if (ev && state_q != S_IDLE) grp_q <= grp_q + 1'b1;
                case (state_q)
                    S_IDLE: begin
                        cnt_q   <= '0;
                        state_q <= S_ARM;
                    end
                    S_ARM: begin
                        if (ev) begin
                            state_q <= S_MEASURE;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_inc_d;
                            if (at_limit) begin
                                state_q   <= S_TMO;
                                timeout_q <= 1'b1;
                            end
                        end
                    end
                    S_MEASURE: begin
                        if (ev) begin
                            cnt_q <= '0;
`ifdef FBMON_OVERRUN_EN
                            if (valid_q && !period_ready) begin
                                overrun_q <= 1'b1;
                            end else begin
                                period_q <= cnt_inc_d;
                                valid_q  <= 1'b1;
                            end
`else
                            period_q <= cnt_inc_d;
                            valid_q  <= 1'b1;
`endif
                        end else begin
                            cnt_q <= cnt_inc_d;
                            if (at_limit) begin
                                state_q   <= S_TMO;
                                timeout_q <= 1'b1;
                            end
                        end
                    end
                    S_TMO: begin
                        if (ev) begin
                            state_q <= S_MEASURE;
                            cnt_q   <= '0;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign period_out   = period_q;
    assign period_valid = valid_q;
    assign group_count  = grp_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_feedback_period_monitor.sv
// Directed bench for feedback_period_monitor: a TIMEOUT=100 instance for the main behaviour and
// a CNT_W=4/GRP_W=2 instance for saturation and wrap. Expectations follow FBMON_OVERRUN_EN.
module tb_feedback_period_monitor;

    logic        sysclk = 1'b0;
    logic        reset;
    logic        clr_flags;

    logic        fb_a, en_a, rdy_a;
    logic [15:0] per_a;
    logic        pv_a, tmo_a, ovr_a;
    logic [7:0]  grp_a;

    logic        fb_b, en_b, rdy_b;
    logic [3:0]  per_b;
    logic        pv_b, tmo_b, ovr_b;
    logic [1:0]  grp_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 sysclk = ~sysclk;

    feedback_period_monitor #(.CNT_W(16), .GRP_W(8), .TIMEOUT(100)) u_dut (
        .sysclk(sysclk), .reset(reset), .fb_in(fb_a), .enable(en_a), .clr_flags(clr_flags),
        .period_ready(rdy_a), .period_out(per_a), .period_valid(pv_a), .group_count(grp_a),
        .timeout(tmo_a), .overrun(ovr_a)
    );

    feedback_period_monitor #(.CNT_W(4), .GRP_W(2), .TIMEOUT(21)) u_bnd (
        .sysclk(sysclk), .reset(reset), .fb_in(fb_b), .enable(en_b), .clr_flags(clr_flags),
        .period_ready(rdy_b), .period_out(per_b), .period_valid(pv_b), .group_count(grp_b),
        .timeout(tmo_b), .overrun(ovr_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge sysclk);
            #1;
        end
    endtask

    // Low for one cycle; returns just after the edge that sees the event.
    task automatic pulse_a();
        fb_a = 1'b0;
        cyc(1);
        fb_a = 1'b1;
    endtask

    task automatic pulse_b();
        fb_b = 1'b0;
        cyc(1);
        fb_b = 1'b1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_per"},  32'(per_a), 32'd0);
        check({tag, "_pv"},   32'(pv_a),  32'd0);
        check({tag, "_grp"},  32'(grp_a), 32'd0);
        check({tag, "_tmo"},  32'(tmo_a), 32'd0);
        check({tag, "_ovr"},  32'(ovr_a), 32'd0);
    endtask

    logic [31:0] exp_bp_per;
    logic [31:0] exp_bp_ovr;

    initial begin
`ifdef FBMON_OVERRUN_EN
        exp_bp_per = 32'd40;
        exp_bp_ovr = 32'd1;
`else
        exp_bp_per = 32'd30;
        exp_bp_ovr = 32'd0;
`endif
        reset = 1'b0; clr_flags = 1'b0;
        fb_a = 1'b1; en_a = 1'b0; rdy_a = 1'b0;
        fb_b = 1'b1; en_b = 1'b0; rdy_b = 1'b1;
        #2;
        cyc(2);
        check_reset_vals("rst");
        check("rst_b_per", 32'(per_b), 32'd0);
        check("rst_b_grp", 32'(grp_b), 32'd0);

        // Disabled: marker activity must be ignored, no timeout in IDLE
        reset = 1'b1;
        for (int i = 0; i < 40; i++) begin
            fb_a = ~fb_a;
            cyc(3);
        end
        check_reset_vals("idle");

        // Steady 40-cycle period
        rdy_a = 1'b1; en_a = 1'b1;
        cyc(1);
        pulse_a();
        check("first_pv",  32'(pv_a),  32'd0);
        check("first_grp", 32'(grp_a), 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc(39);
            pulse_a();
            check("steady_per", 32'(per_a), 32'd40);
            check("steady_pv",  32'(pv_a),  32'd1);
            check("steady_grp", 32'(grp_a), 32'(2 + i));
        end
        cyc(1);
        check("xfer_pv", 32'(pv_a), 32'd0);

        // Backpressure across two captures (40 then 30)
        rdy_a = 1'b0;
        cyc(38);
        pulse_a();
        check("bp1_per", 32'(per_a), 32'd40);
        check("bp1_pv",  32'(pv_a),  32'd1);
        check("bp1_grp", 32'(grp_a), 32'd5);
        cyc(10);
        check("bp_hold_per", 32'(per_a), 32'd40);
        check("bp_hold_pv",  32'(pv_a),  32'd1);
        cyc(19);
        pulse_a();
        check("bp2_per", 32'(per_a), exp_bp_per);
        check("bp2_ovr", 32'(ovr_a), exp_bp_ovr);
        check("bp2_pv",  32'(pv_a),  32'd1);
        check("bp2_grp", 32'(grp_a), 32'd6);
        rdy_a = 1'b1;
        cyc(1);
        rdy_a = 1'b0;
        check("bp_xfer_pv", 32'(pv_a), 32'd0);
        check("bp_ovr_sticky", 32'(ovr_a), exp_bp_ovr);
        clr_flags = 1'b1;
        cyc(1);
        clr_flags = 1'b0;
        check("clr_ovr", 32'(ovr_a), 32'd0);

        // Capture while idle-valid, then capture coinciding with a transfer
        cyc(22);
        pulse_a();
        check("p25_per", 32'(per_a), 32'd25);
        check("p25_pv",  32'(pv_a),  32'd1);
        cyc(34);
        fb_a = 1'b0; rdy_a = 1'b1;
        cyc(1);
        fb_a = 1'b1; rdy_a = 1'b0;
        check("capxfer_per", 32'(per_a), 32'd35);
        check("capxfer_pv",  32'(pv_a),  32'd1);
        check("capxfer_ovr", 32'(ovr_a), 32'd0);
        check("capxfer_grp", 32'(grp_a), 32'd8);
        rdy_a = 1'b1;
        cyc(1);
        check("capxfer_drain", 32'(pv_a), 32'd0);

        // Timeout: event at k, flag exactly after k+100; clr held high loses to the set
        pulse_a();
        check("p2_per", 32'(per_a), 32'd2);
        clr_flags = 1'b1;
        cyc(99);
        check("tmo_early", 32'(tmo_a), 32'd0);
        cyc(1);
        check("tmo_set", 32'(tmo_a), 32'd1);
        clr_flags = 1'b0;
        cyc(50);
        pulse_a();
        check("tmo_rearm_per", 32'(per_a), 32'd2);
        check("tmo_rearm_pv",  32'(pv_a),  32'd0);
        check("tmo_rearm_grp", 32'(grp_a), 32'd10);
        rdy_a = 1'b0;
        cyc(44);
        pulse_a();
        check("tmo_next_per", 32'(per_a), 32'd45);
        check("tmo_next_pv",  32'(pv_a),  32'd1);
        check("tmo_sticky",   32'(tmo_a), 32'd1);
        clr_flags = 1'b1;
        cyc(1);
        clr_flags = 1'b0;
        check("tmo_clr", 32'(tmo_a), 32'd0);

        // Disable with a pending value, then re-enable
        en_a = 1'b0;
        cyc(1);
        check("dis_pv",  32'(pv_a),  32'd0);
        check("dis_grp", 32'(grp_a), 32'd11);
        check("dis_per", 32'(per_a), 32'd45);
        en_a = 1'b1;
        cyc(1);
        pulse_a();
        check("reen_pv",  32'(pv_a),  32'd0);
        check("reen_grp", 32'(grp_a), 32'd12);
        cyc(19);
        pulse_a();
        check("reen_per", 32'(per_a), 32'd20);
        check("reen_pv2", 32'(pv_a),  32'd1);

        // Reset mid-MEASURE with the marker held low through it
        cyc(5);
        reset = 1'b0; fb_a = 1'b0;
        cyc(1);
        check_reset_vals("midrst");
        reset = 1'b1;
        cyc(3);
        check("midrst_grp_after", 32'(grp_a), 32'd0);
        check("midrst_pv_after",  32'(pv_a),  32'd0);
        fb_a = 1'b1;
        cyc(1);
        pulse_a();
        check("midrst_first_grp", 32'(grp_a), 32'd1);
        check("midrst_first_pv",  32'(pv_a),  32'd0);

        // Narrow instance: saturation, held-low marker, group wrap
        en_b = 1'b1;
        cyc(1);
        pulse_b();
        check("b_first_grp", 32'(grp_b), 32'd1);
        check("b_first_pv",  32'(pv_b),  32'd0);
        cyc(19);
        pulse_b();
        check("b_sat_per", 32'(per_b), 32'd15);
        check("b_sat_pv",  32'(pv_b),  32'd1);
        check("b_sat_grp", 32'(grp_b), 32'd2);
        cyc(9);
        fb_b = 1'b0;
        cyc(1);
        check("b_hold_grp", 32'(grp_b), 32'd3);
        check("b_hold_per", 32'(per_b), 32'd10);
        cyc(4);
        check("b_hold_grp5", 32'(grp_b), 32'd3);
        fb_b = 1'b1;
        cyc(3);
        pulse_b();
        check("b_wrap0", 32'(grp_b), 32'd0);
        cyc(3);
        pulse_b();
        check("b_wrap1", 32'(grp_b), 32'd1);
        cyc(40);
        check("b_no_tmo", 32'(tmo_b), 32'd0);
        check("b_no_ovr", 32'(ovr_b), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
